// File: rtl/dfe_ctrl_pkg.sv
// Shared types for the DFE tap-load controller: FSM state encoding, default
// tap count and the tap word field layout.
package dfe_ctrl_pkg;

  localparam int DEF_NUM_TAPS = 5;

  localparam int TAP_MANT_MSB  = 31;
  localparam int TAP_MANT_LSB  = 16;
  localparam int TAP_SHIFT_MSB = 15;
  localparam int TAP_SHIFT_LSB = 0;

  typedef struct packed {
    logic [TAP_MANT_MSB-TAP_MANT_LSB:0]   mant;
    logic [TAP_SHIFT_MSB-TAP_SHIFT_LSB:0] shift;
  } tap_word_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_LOAD,
    ST_SETTLE,
    ST_HANDOFF,
    ST_RUN,
    ST_ERR
  } dfe_state_e;

endpackage

// File: rtl/dfe_cycle_counter.sv
// Loadable down-counter with terminal-count flag; shared by the memory-latency,
// settle and handoff-timeout phases of the tap-load sequence.
module dfe_cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/dfe_tap_load_ctrl.sv
// Sequences pulse-response taps from coefficient memory into the DFE, then
// hands off to live sample traffic once the DFE reports its load complete.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | one-cycle memory read strobe for tap idx
// WAIT    | memory latency, capture word on last cycle
// LOAD    | one-cycle DFE write of tap idx
// SETTLE  | repeat last tap write SETTLE_PULSES times
// HANDOFF | wait for dfe_done, bounded by TIMEOUT
// RUN     | samples pass through; terminal until reset
// ERR     | dfe_done timed out; start retries
module dfe_tap_load_ctrl
  import dfe_ctrl_pkg::*;
#(
  parameter int NUM_TAPS      = DEF_NUM_TAPS,
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 64,
  parameter int MEM_LAT       = 2,
  parameter int SETTLE_PULSES = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              load_mem,
  output logic [7:0]        location,
  output logic [DATA_W-1:0] mem_data,
  input  logic              dfe_done,
  input  logic              sample_valid_in,
  output logic              sample_valid_out,
  output logic              busy,
  output logic              ready,
  output logic              err
);

  localparam int CNT_MAX_A = (TIMEOUT > MEM_LAT) ? TIMEOUT : MEM_LAT;
  localparam int CNT_MAX   = (CNT_MAX_A > SETTLE_PULSES) ? CNT_MAX_A : SETTLE_PULSES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [7:0]       LAST_IDX   = 8'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] SET_LOAD   = CNT_W'(SETTLE_PULSES - 1);
  localparam logic [CNT_W-1:0] TOUT_LOAD  = CNT_W'(TIMEOUT - 1);

  dfe_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        idx_q;
  logic [7:0]        loc_q;
  logic [DATA_W-1:0] data_q;

  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_dec;
  logic              cnt_tc;
  logic              latch_base;
  logic              capture;
  logic              idx_inc;

  dfe_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    latch_base = 1'b0;
    capture    = 1'b0;
    idx_inc    = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          latch_base = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: begin
        cnt_load = 1'b1;
        cnt_val  = LAT_LOAD;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_tc) begin
          capture = 1'b1;
          state_d = ST_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_LOAD: begin
        idx_inc = 1'b1;
        if (idx_q < LAST_IDX) begin
          state_d = ST_FETCH;
        end else if (SETTLE_PULSES == 0) begin
          cnt_load = 1'b1;
          cnt_val  = TOUT_LOAD;
          state_d  = ST_HANDOFF;
        end else begin
          cnt_load = 1'b1;
          cnt_val  = SET_LOAD;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_tc) begin
          cnt_load = 1'b1;
          cnt_val  = TOUT_LOAD;
          state_d  = ST_HANDOFF;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HANDOFF: begin
        // dfe_done wins over a coincident start and over the last timeout cycle
        if (dfe_done) begin
          state_d = ST_RUN;
        end else if (cnt_tc) begin
          state_d = ST_ERR;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q <= '0;
      idx_q  <= '0;
      loc_q  <= '0;
      data_q <= '0;
    end else begin
      if (latch_base) begin
        base_q <= base_addr;
        idx_q  <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + 8'd1;
      end
      // location and word update together on LOAD entry and hold through SETTLE
      if (capture) begin
        data_q <= mem_rd_data;
        loc_q  <= idx_q;
      end
    end
  end

  assign mem_addr         = base_q + ADDR_W'(idx_q);
  assign mem_rd_en        = (state_q == ST_FETCH);
  assign load_mem         = (state_q == ST_LOAD) || (state_q == ST_SETTLE);
  assign location         = loc_q;
  assign mem_data         = data_q;
  assign busy             = (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                            (state_q == ST_LOAD)  || (state_q == ST_SETTLE) ||
                            (state_q == ST_HANDOFF);
  assign ready            = (state_q == ST_RUN);
  assign err              = (state_q == ST_ERR);
  assign sample_valid_out = (state_q == ST_RUN) && sample_valid_in;

endmodule

// File: tb/tb_dfe_tap_load_ctrl.sv
// Directed bench for dfe_tap_load_ctrl with a fixed-latency memory model
// returning word = address + 1.
module tb_dfe_tap_load_ctrl;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [7:0]  base_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [63:0] mem_rd_data;
  logic        load_mem;
  logic [7:0]  location;
  logic [63:0] mem_data;
  logic        dfe_done;
  logic        sample_valid_in;
  logic        sample_valid_out;
  logic        busy;
  logic        ready;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int          n_ld = 0;
  int          n_rd = 0;
  logic [7:0]  ld_loc  [64];
  logic [63:0] ld_data [64];
  int          ld_cyc  [64];
  logic [7:0]  rd_addr [64];

  logic [7:0]         pa [MEM_LAT];
  logic [MEM_LAT-1:0] pv = '0;

  dfe_tap_load_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .base_addr        (base_addr),
    .mem_rd_en        (mem_rd_en),
    .mem_addr         (mem_addr),
    .mem_rd_data      (mem_rd_data),
    .load_mem         (load_mem),
    .location         (location),
    .mem_data         (mem_data),
    .dfe_done         (dfe_done),
    .sample_valid_in  (sample_valid_in),
    .sample_valid_out (sample_valid_out),
    .busy             (busy),
    .ready            (ready),
    .err              (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      pa[i] <= pa[i-1];
      pv[i] <= pv[i-1];
    end
    pa[0] <= mem_addr;
    pv[0] <= mem_rd_en;
  end

  assign mem_rd_data = pv[MEM_LAT-1] ? (64'(pa[MEM_LAT-1]) + 64'd1) : 64'hDEAD_BEEF_0000_0000;

  always @(negedge clk) begin
    if (load_mem && n_ld < 64) begin
      ld_loc[n_ld]  = location;
      ld_data[n_ld] = mem_data;
      ld_cyc[n_ld]  = cyc;
      n_ld++;
    end
    if (mem_rd_en && n_rd < 64) begin
      rd_addr[n_rd] = mem_addr;
      n_rd++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // returns at the first HANDOFF cycle: all strobes seen, busy, no load pulse
  task automatic wait_handoff(input int ld0, input int n_exp, output int hcyc);
    int k;
    k = 0;
    while (!((n_ld - ld0) == n_exp && !load_mem && busy) && k < 200) begin
      tick();
      k++;
    end
    chk("handoff_reached", 64'(k < 200), 64'd1);
    hcyc = cyc;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_addr"},  64'(mem_addr), 64'd0);
    chk({tag, "_load"},  64'(load_mem), 64'd0);
    chk({tag, "_loc"},   64'(location), 64'd0);
    chk({tag, "_data"},  mem_data, 64'd0);
    chk({tag, "_svo"},   64'(sample_valid_out), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(ready), 64'd0);
    chk({tag, "_err"},   64'(err), 64'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    int t0, hc, ld0, rd0;
    logic [7:0]  exp_loc  [7];
    logic [63:0] exp_data [7];
    logic [7:0]  exp_wrap [5];
    exp_loc  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4};
    exp_data = '{64'h11, 64'h12, 64'h13, 64'h14, 64'h15, 64'h15, 64'h15};
    exp_wrap = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};

    rstn = 1'b0; start = 1'b0; base_addr = 8'h00; dfe_done = 1'b0; sample_valid_in = 1'b1;
    tick(2);
    check_idle_outputs("rst");
    rstn = 1'b1;
    tick();

    // normal load, start held into FETCH and re-pulsed in LOAD
    ld0 = n_ld; rd0 = n_rd;
    start = 1'b1; base_addr = 8'h10;
    tick();
    t0 = cyc;
    chk("fetch0_rd_en", 64'(mem_rd_en), 64'd1);
    chk("fetch0_addr", 64'(mem_addr), 64'h10);
    chk("fetch0_busy", 64'(busy), 64'd1);
    tick();
    start = 1'b0;
    chk("wait0_rd_en", 64'(mem_rd_en), 64'd0);
    tick(6);
    chk("load1_strobe", 64'(load_mem), 64'd1);
    chk("load1_loc", 64'(location), 64'd1);
    chk("load1_data", mem_data, 64'h12);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch2_addr", 64'(mem_addr), 64'h12);
    chk("fetch2_rd_en", 64'(mem_rd_en), 64'd1);
    wait_handoff(ld0, 7, hc);
    chk("handoff_latency", 64'(hc - t0), 64'd22);
    chk("n_loads", 64'(n_ld - ld0), 64'd7);
    chk("n_reads", 64'(n_rd - rd0), 64'd5);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("ld%0d_loc", i), 64'(ld_loc[ld0+i]), 64'(exp_loc[i]));
      chk($sformatf("ld%0d_data", i), ld_data[ld0+i], exp_data[i]);
      chk($sformatf("ld%0d_cyc", i), 64'(ld_cyc[ld0+i] - t0), 64'(i < 5 ? 4*i + 3 : 15 + i));
    end
    for (int i = 0; i < 5; i++)
      chk($sformatf("rd%0d_addr", i), 64'(rd_addr[rd0+i]), 64'(8'h10 + 8'(i)));
    chk("ho_busy", 64'(busy), 64'd1);
    chk("ho_ready", 64'(ready), 64'd0);
    chk("ho_svo_gated", 64'(sample_valid_out), 64'd0);

    // dfe_done 3 cycles into HANDOFF, with a coincident start
    tick(2);
    dfe_done = 1'b1; start = 1'b1;
    chk("ho3_ready", 64'(ready), 64'd0);
    tick();
    dfe_done = 1'b0; start = 1'b0;
    chk("run_ready", 64'(ready), 64'd1);
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_svo_hi", 64'(sample_valid_out), 64'd1);
    sample_valid_in = 1'b0; #1;
    chk("run_svo_lo", 64'(sample_valid_out), 64'd0);
    sample_valid_in = 1'b1; #1;
    chk("run_svo_hi2", 64'(sample_valid_out), 64'd1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(5);
    chk("run_start_ready", 64'(ready), 64'd1);
    chk("run_start_reads", 64'(n_rd - rd0), 64'd5);
    chk("run_start_loads", 64'(n_ld - ld0), 64'd7);

    // timeout to ERR, then restart from tap 0
    do_reset();
    ld0 = n_ld; rd0 = n_rd;
    start = 1'b1; base_addr = 8'h10;
    tick();
    start = 1'b0;
    wait_handoff(ld0, 7, hc);
    tick(63);
    chk("to63_err", 64'(err), 64'd0);
    chk("to63_busy", 64'(busy), 64'd1);
    tick();
    chk("to64_err", 64'(err), 64'd1);
    chk("to64_load", 64'(load_mem), 64'd0);
    chk("to64_busy", 64'(busy), 64'd0);
    chk("to64_svo", 64'(sample_valid_out), 64'd0);
    tick(3);
    chk("err_hold", 64'(err), 64'd1);
    ld0 = n_ld; rd0 = n_rd;
    start = 1'b1; base_addr = 8'h30;
    tick();
    start = 1'b0;
    chk("restart_err", 64'(err), 64'd0);
    chk("restart_addr", 64'(mem_addr), 64'h30);
    wait_handoff(ld0, 7, hc);
    chk("restart_loc0", 64'(ld_loc[ld0]), 64'd0);
    chk("restart_data0", ld_data[ld0], 64'h31);

    // address wrap
    do_reset();
    rd0 = n_rd; ld0 = n_ld;
    start = 1'b1; base_addr = 8'hFE;
    tick();
    start = 1'b0;
    wait_handoff(ld0, 7, hc);
    for (int i = 0; i < 5; i++)
      chk($sformatf("wrap%0d_addr", i), 64'(rd_addr[rd0+i]), 64'(exp_wrap[i]));
    chk("wrap_data4", ld_data[ld0+4], 64'h03);

    // reset during tap 2 WAIT
    do_reset();
    ld0 = n_ld;
    start = 1'b1; base_addr = 8'h10;
    tick();
    start = 1'b0;
    tick(9);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_loads", 64'(n_ld - ld0), 64'd2);
    rstn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    tick(3);
    rstn = 1'b1;
    tick(30);
    chk("post_rst_loads", 64'(n_ld - ld0), 64'd2);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dfe_tap_load_ctrl.md
DFE_TAP_LOAD_CTRL -- requirements
Module: dfe_tap_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 5, number of pulse-response taps to load.
REQ-002 SHALL have parameter ADDR_W, default 8, coefficient-memory address width.
REQ-003 SHALL have parameter DATA_W, default 64, coefficient word width.
REQ-004 SHALL have parameter MEM_LAT, default 2, fixed read latency in cycles from mem_rd_en to valid mem_rd_data, range 1..7.
REQ-005 SHALL have parameter SETTLE_PULSES, default 2, number of extra load pulses after the last tap.
REQ-006 SHALL have parameter TIMEOUT, default 64, number of cycles to wait for dfe_done.
REQ-007 SHALL have ports: clk  in  1  clock; rstn  in  1  reset; reset rstn, asynchronous, active-low; clock clk.
REQ-008 SHALL have ports: start  in  1  load request pulse; base_addr  in  ADDR_W  memory address of tap 0.
REQ-009 SHALL have ports: mem_rd_en  out  1  read strobe; mem_addr  out  ADDR_W  read address; mem_rd_data  in  DATA_W  read data.
REQ-010 SHALL have ports: load_mem  out  1  DFE tap write strobe; location  out  8  tap index; mem_data  out  DATA_W  tap word; dfe_done  in  1  DFE load-complete flag.
REQ-011 SHALL have ports: sample_valid_in  in  1  upstream sample valid; sample_valid_out  out  1  gated valid to the DFE; busy  out  1; ready  out  1; err  out  1.

Function
REQ-012 SHALL implement the FSM states IDLE, FETCH, WAIT, LOAD, SETTLE, HANDOFF, RUN and ERR.
REQ-013 IDLE: a start pulse SHALL latch base_addr, clear the tap index and go to FETCH; start is ignored in all other states except ERR.
REQ-014 FETCH SHALL hold for exactly 1 cycle with mem_rd_en=1 and mem_addr=base+idx (modulo 2^ADDR_W wrap), then go to WAIT.
REQ-015 WAIT SHALL count MEM_LAT cycles after FETCH, capture mem_rd_data into the data register on the MEM_LAT-th cycle, then go to LOAD.
REQ-016 LOAD SHALL hold for 1 cycle with load_mem=1, location=idx and mem_data=captured word; it then increments idx and goes to FETCH if idx<NUM_TAPS-1, otherwise to SETTLE.
REQ-017 SETTLE SHALL keep load_mem=1 for SETTLE_PULSES cycles with location=NUM_TAPS-1 and the last word unchanged (idempotent rewrite), then go to HANDOFF.
REQ-018 HANDOFF SHALL count cycles with load_mem=0, go to RUN on the first cycle with dfe_done=1, and go to ERR if TIMEOUT cycles elapse first.
REQ-019 RUN SHALL set sample_valid_out=sample_valid_in combinationally; in every other state sample_valid_out SHALL be 0.
REQ-020 ERR SHALL hold err=1 and load_mem=0; a start pulse restarts the sequence exactly as in IDLE and clears err.
REQ-021 busy SHALL be 1 in FETCH, WAIT, LOAD, SETTLE and HANDOFF; ready SHALL be 1 only in RUN.
REQ-022 Load cycle count SHALL be NUM_TAPS*(MEM_LAT+2)+SETTLE_PULSES from start to the first HANDOFF cycle (default 22).
REQ-023 mem_data and location SHALL stay stable from the LOAD cycle until the next LOAD cycle.
REQ-024 A start pulse coincident with dfe_done in HANDOFF SHALL be ignored, and the FSM SHALL enter RUN.
REQ-025 RUN SHALL be terminal until reset, because the DFE load counter is cleared only by reset.

Reset
REQ-026 Asserting rstn low SHALL asynchronously force state to IDLE, idx, counters and registers to 0, and all outputs to 0 (mem_rd_en, load_mem, location, mem_data, mem_addr, sample_valid_out, busy, ready, err).
REQ-027 Reset during any state, including mid-load, SHALL abort the sequence with no further strobes; after release the block waits in IDLE for start.

Structure
REQ-028 The shared package dfe_ctrl_pkg SHALL hold the FSM state enum, the default NUM_TAPS, and the tap word field widths (mantissa [31:16], shift [15:0]).
REQ-029 The timeout/latency down-counter SHALL be a single sub-module, dfe_cycle_counter, instantiated once and reused by WAIT, SETTLE and HANDOFF.

Verification
REQ-030 The bench SHALL cover: defaults, base_addr=0x10, memory words 0x11..0x15 -> 5 load pulses at locations 0..4 with matching data, then 2 settle pulses at location 4 / 0x15, with first HANDOFF cycle 22 cycles after start.
REQ-031 The bench SHALL cover: dfe_done asserted 3 cycles into HANDOFF -> ready=1 next cycle; sample_valid_in toggling then appears on sample_valid_out with the same cycle timing.
REQ-032 The bench SHALL cover: dfe_done never asserted -> err=1 after exactly 64 HANDOFF cycles, load_mem=0 and sample_valid_out=0; a start pulse then restarts from tap 0.
REQ-033 The bench SHALL cover: base_addr=0xFE -> mem_addr sequence 0xFE, 0xFF, 0x00, 0x01, 0x02.
REQ-034 The bench SHALL cover: rstn pulsed low during tap 2 WAIT -> all outputs 0 immediately and no load_mem until a new start.
REQ-035 The bench SHALL cover: start re-pulsed during FETCH/LOAD and in RUN -> ignored, with unchanged strobe sequence and ready held at 1.
